// File: rtl/demux_bank_scheduler_if.sv
// Bundle of the coefficient input handshake, bank backpressure and demux/bank
// write outputs of demux_bank_scheduler. The scheduler takes the slave side.
//
// Handshake: a word moves when in_valid & in_ready are both high on a rising
// clk edge. in_ready may fall at any time (bank stall, abort, not running),
// and in_valid has no effect while in_ready is low.
interface demux_bank_scheduler_if #(
    parameter int N     = 9,
    parameter int S     = 3,
    parameter int DEPTH = 4
) ();
    localparam int SEL_W  = (S > 1) ? $clog2(S) : 1;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              start;
    logic              abort;
    logic              in_valid;
    logic [N-1:0]      in_data;
    logic              in_ready;
    logic [S-1:0]      bank_ready;
    logic [N-1:0]      dout;
    logic [SEL_W-1:0]  sel;
    logic [S-1:0]      bank_we;
    logic [ADDR_W-1:0] bank_addr;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, in_valid, in_data, bank_ready,
        input  in_ready, dout, sel, bank_we, bank_addr, busy, done
    );

    modport slave (
        input  start, abort, in_valid, in_data, bank_ready,
        output in_ready, dout, sel, bank_we, bank_addr, busy, done
    );
endinterface

// File: rtl/demux_bank_scheduler.sv
// Distributes a frame of S*DEPTH coefficients round-robin over S banks:
// word k goes to bank k mod S at address k div S. A stalled bank blocks the
// whole stream so ordering is never disturbed. done pulses with the final
// write so the NTT controller can move on.
module demux_bank_scheduler #(
    parameter int N     = 9,
    parameter int S     = 3,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_bank_scheduler_if.slave bus,
    output logic [1:0]           state_dbg
);
    localparam int SEL_W  = (S > 1) ? $clog2(S) : 1;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SEL_W-1:0]  BANK_LAST = SEL_W'(S - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SEL_W-1:0]  bank_ptr;
    logic [ADDR_W-1:0] addr_ptr;
    logic              accept;
    logic              last_word;

    // in_ready never looks at in_valid, so there is no valid->ready loop.
    assign bus.in_ready = (state == RUN) & bus.bank_ready[bank_ptr] & ~bus.abort;
    assign accept       = bus.in_valid & bus.in_ready;
    assign last_word    = accept & (bank_ptr == BANK_LAST) & (addr_ptr == ADDR_LAST);
    assign bus.busy     = (state != IDLE);
    assign state_dbg    = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort wins over start and over the final accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_word) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) state_nxt = IDLE;
    end

    // Bank/address pointers: cleared on start, bank advances per accepted
    // word with an explicit wrap so S need not be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_ptr <= '0;
            addr_ptr <= '0;
        end else if ((state == IDLE) && bus.start && !bus.abort) begin
            bank_ptr <= '0;
            addr_ptr <= '0;
        end else if (accept) begin
            if (bank_ptr == BANK_LAST) begin
                bank_ptr <= '0;
                addr_ptr <= addr_ptr + ADDR_W'(1);
            end else begin
                bank_ptr <= bank_ptr + SEL_W'(1);
            end
        end
    end

    // Registered demux/bank outputs; data, select and address hold between
    // writes, strobes are single-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout      <= '0;
            bus.sel       <= '0;
            bus.bank_addr <= '0;
            bus.bank_we   <= '0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= last_word;
            if (accept) begin
                bus.dout      <= bus.in_data;
                bus.sel       <= bank_ptr;
                bus.bank_addr <= addr_ptr;
                bus.bank_we   <= S'(1) << bank_ptr;
            end else begin
                bus.bank_we   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_demux_bank_scheduler.sv
// Directed plus randomized checks of demux_bank_scheduler against a frame
// model that works from word index k (bank = k mod S, address = k div S).
module tb_demux_bank_scheduler;
    localparam int N  = 9;
    localparam int S  = 3;
    localparam int D  = 4;
    localparam int S2 = 5;
    localparam int D2 = 2;
    localparam int QW = 2 + 2 + N;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_bank_scheduler_if #(.N(N), .S(S), .DEPTH(D)) bus ();
    demux_bank_scheduler_if #(.N(N), .S(S2), .DEPTH(D2)) bus2 ();
    logic [1:0] state_dbg;
    logic [1:0] state_dbg2;

    demux_bank_scheduler #(.N(N), .S(S), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .state_dbg(state_dbg)
    );
    demux_bank_scheduler #(.N(N), .S(S2), .DEPTH(D2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .state_dbg(state_dbg2)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // phase: 0 = not started, 1 = frame open, 2 = frame just completed
    int         m_phase;
    int         m_count;
    logic [N-1:0] m_dout;
    int         m_sel;
    int         m_addr;
    int         m_we;
    int         m_done;
    logic [QW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_count = 0; m_dout = '0; m_sel = 0; m_addr = 0;
        m_we = 0; m_done = 0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        logic [QW-1:0] e;
        check("bank_we", 32'(bus.bank_we), 32'(m_we));
        check("done", 32'(bus.done), 32'(m_done));
        check("busy", 32'(bus.busy), 32'(m_phase != 0));
        check("dout", 32'(bus.dout), 32'(m_dout));
        check("sel", 32'(bus.sel), 32'(m_sel));
        check("bank_addr", 32'(bus.bank_addr), 32'(m_addr));
        if (m_we != 0) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("scoreboard", 32'({2'(bus.sel), 2'(bus.bank_addr), bus.dout}), 32'(e));
            end
        end
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive inputs mid-cycle, check in_ready, advance the
    // model, then check registered outputs just after the edge.
    task automatic step(input logic st, input logic ab, input logic v,
                        input logic [N-1:0] d, input logic [S-1:0] br);
        logic rdy;
        int   b;
        @(negedge clk);
        bus.start = st; bus.abort = ab; bus.in_valid = v;
        bus.in_data = d; bus.bank_ready = br;
        #1;
        b   = m_count % S;
        rdy = (m_phase == 1) && br[b] && !ab;
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        m_we = 0; m_done = 0;
        if (ab) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (st) begin m_phase = 1; m_count = 0; end
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (v && rdy) begin
            m_we   = 1 << b;
            m_sel  = b;
            m_addr = m_count / S;
            m_dout = d;
            exp_q.push_back({2'(b), 2'(m_count / S), d});
            if (m_count == S*D - 1) begin m_done = 1; m_phase = 2; end
            m_count++;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in_data = '0; bus.bank_ready = '0;
        bus2.start = 0; bus2.abort = 0; bus2.in_valid = 0; bus2.in_data = '0; bus2.bank_ready = '0;
        model_reset();
        #12;
        check("reset_in_ready", 32'(bus.in_ready), 32'(0));
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: full frame back to back, all banks ready
        step(1, 0, 0, '0, 3'b111);
        for (int k = 0; k < S*D; k++) step(0, 0, 1, N'(k + 1), 3'b111);
        step(0, 0, 0, '0, 3'b111);
        step(0, 0, 1, 9'h55, 3'b111);

        // 2: stall bank 1 for 5 cycles while word index 1 (second word) waits
        step(1, 0, 0, '0, 3'b111);
        step(0, 0, 1, 9'h011, 3'b111);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 9'h022, 3'b101);
        for (int k = 1; k < S*D; k++) step(0, 0, 1, N'(9'h022 + k - 1), 3'b111);
        step(0, 0, 0, '0, 3'b111);

        // 3: abort after 8 accepted words, then a fresh frame from bank 0
        step(1, 0, 0, '0, 3'b111);
        for (int k = 0; k < 8; k++) step(0, 0, 1, N'(9'h100 + k), 3'b111);
        step(1, 1, 1, 9'h1FF, 3'b111);
        step(0, 0, 1, 9'h1FE, 3'b111);
        step(1, 0, 0, '0, 3'b111);
        step(0, 0, 1, 9'h0AA, 3'b111);
        check("restart_bank", 32'(bus.bank_we), 32'(1));
        check("restart_addr", 32'(bus.bank_addr), 32'(0));

        // 6: start during RUN and valid in IDLE have no effect
        step(1, 0, 0, '0, 3'b111);
        step(0, 0, 1, 9'h0AB, 3'b111);
        step(1, 0, 0, '0, 3'b111);
        step(0, 1, 0, '0, 3'b111);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 9'h0CC, 3'b111);

        // randomized traffic, stalls, aborts and restarts
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0), N'($urandom),
                 S'($urandom_range(0, 1) ? 7 : $urandom_range(0, 7)));
        end

        // 4: asynchronous reset mid-frame
        step(1, 0, 0, '0, 3'b111);
        for (int k = 0; k < 5; k++) step(0, 0, 1, N'(9'h150 + k), 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_in_ready", 32'(bus.in_ready), 32'(0));
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 9'h077, 3'b111);
        step(1, 0, 0, '0, 3'b111);
        step(0, 0, 1, 9'h078, 3'b111);
        check("post_reset_bank", 32'(bus.bank_we), 32'(1));

        // 5: second instance, S=5 DEPTH=2
        @(negedge clk);
        bus2.start = 1; bus2.bank_ready = '1;
        @(posedge clk); #1;
        check("s5_busy", 32'(bus2.busy), 32'(1));
        for (int k = 0; k < S2*D2; k++) begin
            @(negedge clk);
            bus2.start = 0; bus2.in_valid = 1; bus2.in_data = N'(k + 1);
            #1;
            check("s5_in_ready", 32'(bus2.in_ready), 32'(1));
            @(posedge clk); #1;
            check("s5_sel", 32'(bus2.sel), 32'(k % S2));
            check("s5_addr", 32'(bus2.bank_addr), 32'(k / S2));
            check("s5_we", 32'(bus2.bank_we), 32'(1 << (k % S2)));
            check("s5_dout", 32'(bus2.dout), 32'(k + 1));
            check("s5_done", 32'(bus2.done), 32'(k == S2*D2 - 1));
        end
        @(negedge clk);
        bus2.in_valid = 0;
        @(posedge clk); #1;
        check("s5_idle", 32'(bus2.busy), 32'(0));
        check("s5_we_idle", 32'(bus2.bank_we), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
